hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//  Central stall/flush/forwarding sequencer for the 5-stage MIPS pipeline; replaces ad-hoc hazard logic.
//  Drives the PC/IF_ID hold+flush, ID_EX bubble and EX-stage forwarding selects (Fw1/Fw2).
//  Branches and jumps resolve in ID; a multi-cycle mult/div unit is sequenced via an FSM with timeout.
// PARAMETERS
//  CNT_W       16   width of stall_count
//  MD_TIMEOUT  32   max cycles in MD_WAIT before forced exit (>=2)
// PORTS
//  clock           in   1   rising-edge clock
//  reset           in   1   synchronous, active-high
//  id_rs, id_rt    in   5   source regs of instruction in ID
//  id_uses_rt      in   1   ID instr reads rt (R-type, beq/bne, sw)
//  id_is_branch    in   1   ID instr is beq/bne
//  id_branch_taken in   1   branch compare result in ID (valid with id_is_branch)
//  id_is_jump      in   1   ID instr is j/jal/jr
//  id_md_start     in   1   ID instr issues mult/div
//  md_done         in   1   mult/div unit finished (1-cycle pulse)
//  ex_mem_read     in   1   EX instr is lw
//  ex_reg_write    in   1   EX instr writes ex_rd
//  ex_rd           in   5   EX dest reg
//  mem_mem_read    in   1   MEM instr is lw
//  mem_reg_write   in   1   MEM instr writes mem_rd
//  mem_rd          in   5   MEM dest reg
//  wb_reg_write    in   1   WB instr writes wb_rd
//  wb_rd           in   5   WB dest reg
//  pc_hold         out  1   freeze PC
//  if_id_hold      out  1   freeze IF_ID
//  if_id_flush     out  1   zero IF_ID next edge
//  id_ex_flush     out  1   insert bubble into ID_EX
//  fw1, fw2        out  2   EX ALU operand A/B select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  md_timeout      out  1   1-cycle pulse on MD_WAIT timeout exit
//  stall_count     out  CNT_W  cycles with pc_hold=1, saturating
// BEHAVIOUR
//  - Reset: state=RUN, ex_rs=ex_rt=0, md_cnt=0, stall_count=0; all outputs 0 while reset=1.
//  - Match(r,d) := d!=0 && d==r; rt compared only if id_uses_rt.
//  - load_use = ex_mem_read && (Match(id_rs,ex_rd) || Match(id_rt,ex_rd)).
//  - br_dep = id_is_branch && ((ex_reg_write && match vs ex_rd) || (mem_mem_read && match vs mem_rd)).
//  - stall = load_use || br_dep. Outputs are combinational from state+inputs.
//  - FSM RUN:
//     stall: pc_hold=if_id_hold=id_ex_flush=1, if_id_flush=0 (branch/jump ignored this cycle).
//     else (id_is_branch&&id_branch_taken)||id_is_jump: if_id_flush=1 for exactly that cycle.
//     else id_md_start: next=MD_WAIT, md_cnt<=0 (md instr itself advances to EX this edge).
//  - FSM MD_WAIT: pc_hold=if_id_hold=id_ex_flush=1; md_cnt++ each cycle.
//     md_done -> RUN next edge (done wins if same cycle as timeout).
//     md_cnt==MD_TIMEOUT-1 && !md_done -> RUN, md_timeout=1 that cycle.
//     ID hazard/branch inputs ignored in MD_WAIT.
//  - ex_rs/ex_rt shadow regs: on edge, if id_ex_flush -> 0; else if !if_id_hold -> id_rs/id_rt.
//  - fw1 (ex_rs): 10 if mem_reg_write&&Match(ex_rs,mem_rd); else 01 if wb_reg_write&&Match(ex_rs,wb_rd); else 00.
//    fw2 same on ex_rt. EX/MEM has priority over MEM/WB.
//  - stall_count += 1 each cycle pc_hold=1; saturates at all-ones.
//  - Reset mid-MD_WAIT: back to RUN next edge, no md_timeout pulse.
// TESTING
//  1 lw $t0 in EX (ex_rd=8), ID add rs=8 -> 1 cycle pc_hold=if_id_hold=id_ex_flush=1, then fw1=01 on add in EX.
//  2 ID beq rs=9, EX writes $t1 -> 1 stall; next cycle taken -> if_id_flush=1 one cycle only.
//  3 ex_rd=0 with ex_mem_read=1, id_rs=0 -> no stall; fw1 stays 00 for $zero.
//  4 mem_rd=wb_rd=16 both writing, ex_rs=16 -> fw1=10; clear mem_reg_write -> fw1=01.
//  5 id_md_start, md_done at 5th MD_WAIT cycle -> 5 stall cycles, stall_count+=5, back to RUN.
//  6 MD_TIMEOUT=4, no md_done -> 4 stall cycles, md_timeout pulse on 4th; reset at cycle 2 -> RUN, no pulse.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Pipeline-side view of the hazard controller: per-stage register tags and
// controls in, stall/flush/forwarding controls out.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             id_branch_taken;
  logic             id_is_jump;
  logic             id_md_start;
  logic             md_done;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [4:0]       ex_rd;
  logic             mem_mem_read;
  logic             mem_reg_write;
  logic [4:0]       mem_rd;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic             pc_hold;
  logic             if_id_hold;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       fw1;
  logic [1:0]       fw2;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken, id_is_jump,
           id_md_start, md_done, ex_mem_read, ex_reg_write, ex_rd,
           mem_mem_read, mem_reg_write, mem_rd, wb_reg_write, wb_rd,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_flush, fw1, fw2,
           md_timeout, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken, id_is_jump,
           id_md_start, md_done, ex_mem_read, ex_reg_write, ex_rd,
           mem_mem_read, mem_reg_write, mem_rd, wb_reg_write, wb_rd,
    output pc_hold, if_id_hold, if_id_flush, id_ex_flush, fw1, fw2,
           md_timeout, stall_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush/forwarding sequencer for the 5-stage MIPS pipeline, including the
// mult/div wait FSM with timeout. Outputs are combinational from state+inputs.
module hazard_controller #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 32
) (
  input logic               clock,
  input logic               reset,
  hazard_controller_if.slave hc
);

  localparam int MD_W = $clog2(MD_TIMEOUT);
  localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [MD_W-1:0]  md_cnt_r;
  logic [4:0]       ex_rs_r;
  logic [4:0]       ex_rt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic rt_ex_s;
  logic load_use_s;
  logic br_dep_s;
  logic stall_s;
  logic hold_s;
  logic if_id_flush_s;
  logic timeout_s;
  logic [1:0] fw1_s;
  logic [1:0] fw2_s;

  // $zero never creates a dependency.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] d);
    return (d != 5'd0) && (d == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mem_we, input logic [4:0] mem_d,
                                         input logic wb_we, input logic [4:0] wb_d);
    logic [1:0] sel;
    if (mem_we && reg_match(src, mem_d)) begin
      sel = 2'b10;
    end else if (wb_we && reg_match(src, wb_d)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // ID-stage dependency detection against EX and MEM producers.
  always_comb begin
    rt_ex_s    = hc.id_uses_rt && reg_match(hc.id_rt, hc.ex_rd);
    load_use_s = hc.ex_mem_read && (reg_match(hc.id_rs, hc.ex_rd) || rt_ex_s);
    br_dep_s   = hc.id_is_branch &&
                 ((hc.ex_reg_write && (reg_match(hc.id_rs, hc.ex_rd) || rt_ex_s)) ||
                  (hc.mem_mem_read && (reg_match(hc.id_rs, hc.mem_rd) ||
                                       (hc.id_uses_rt && reg_match(hc.id_rt, hc.mem_rd)))));
    stall_s    = load_use_s || br_dep_s;
  end

  // Next-state and control decode; a stall suppresses branch/jump flush.
  always_comb begin
    state_s       = state_r;
    hold_s        = 1'b0;
    if_id_flush_s = 1'b0;
    timeout_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (stall_s) begin
          hold_s = 1'b1;
        end else if ((hc.id_is_branch && hc.id_branch_taken) || hc.id_is_jump) begin
          if_id_flush_s = 1'b1;
        end else if (hc.id_md_start) begin
          state_s = MD_WAIT;
        end else begin
          state_s = RUN;
        end
      end
      MD_WAIT: begin
        hold_s = 1'b1;
        if (hc.md_done) begin
          state_s = RUN;
        end else if (md_cnt_r == MD_LAST) begin
          state_s   = RUN;
          timeout_s = 1'b1;
        end else begin
          state_s = MD_WAIT;
        end
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  // EX-stage operand forwarding; EX/MEM beats MEM/WB.
  always_comb begin
    fw1_s = fwd_sel(ex_rs_r, hc.mem_reg_write, hc.mem_rd, hc.wb_reg_write, hc.wb_rd);
    fw2_s = fwd_sel(ex_rt_r, hc.mem_reg_write, hc.mem_rd, hc.wb_reg_write, hc.wb_rd);
  end

  // Everything is forced low while reset is asserted.
  assign hc.pc_hold     = hold_s & ~reset;
  assign hc.if_id_hold  = hold_s & ~reset;
  assign hc.id_ex_flush = hold_s & ~reset;
  assign hc.if_id_flush = if_id_flush_s & ~reset;
  assign hc.md_timeout  = timeout_s & ~reset;
  assign hc.fw1         = reset ? 2'b00 : fw1_s;
  assign hc.fw2         = reset ? 2'b00 : fw2_s;
  assign hc.stall_count = reset ? {CNT_W{1'b0}} : stall_cnt_r;

  // State, mult/div cycle counter, EX source shadows and stall statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= RUN;
      md_cnt_r    <= {MD_W{1'b0}};
      ex_rs_r     <= 5'd0;
      ex_rt_r     <= 5'd0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == MD_WAIT) begin
        md_cnt_r <= md_cnt_r + MD_W'(1);
      end else begin
        md_cnt_r <= {MD_W{1'b0}};
      end
      if (hold_s) begin
        ex_rs_r <= 5'd0;
        ex_rt_r <= 5'd0;
      end else begin
        ex_rs_r <= hc.id_rs;
        ex_rt_r <= hc.id_rt;
      end
      if (hold_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

endmodule
